// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer between the row and column DCT passes.
// Rows of W-bit words fill one bank while the other bank drains column by column.
module dct_transpose_buffer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] N0,
    input  logic [W-1:0] N1,
    input  logic [W-1:0] N2,
    input  logic [W-1:0] N3,
    input  logic [W-1:0] N4,
    input  logic [W-1:0] N5,
    input  logic [W-1:0] N6,
    input  logic [W-1:0] N7,
    output logic [W-1:0] O0,
    output logic [W-1:0] O1,
    output logic [W-1:0] O2,
    output logic [W-1:0] O3,
    output logic [W-1:0] O4,
    output logic [W-1:0] O5,
    output logic [W-1:0] O6,
    output logic [W-1:0] O7,
    output logic         valid,
    input  logic         out_ready
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] bank [2][8][8];
    logic [W-1:0] din [8];
    logic [W-1:0] col_p1 [8];
    logic         wr_bank;
    logic         rd_bank;
    logic [2:0]   wr_row;
    logic [2:0]   rd_col;
    logic [1:0]   full;
    logic [1:0]   full_nxt;
    logic         wr_fire;
    logic         rd_start;
    logic         rd_load;
    logic         rd_last;

    always_comb begin
        din[0] = N0;
        din[1] = N1;
        din[2] = N2;
        din[3] = N3;
        din[4] = N4;
        din[5] = N5;
        din[6] = N6;
        din[7] = N7;
    end

    // in_ready depends on registered flags only, never on out_ready
    assign in_ready = ~full[wr_bank];
    assign wr_fire  = en & in_valid & in_ready;

    // Read FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    // Read FSM: next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (full[rd_bank]) state_nxt = DRAIN;
            DRAIN:   if (rd_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read FSM: outputs
    always_comb begin
        rd_start = 1'b0;
        rd_load  = 1'b0;
        case (state)
            IDLE:    rd_start = en & full[rd_bank];
            DRAIN:   rd_load  = en & (~valid | out_ready);
            default: ;
        endcase
    end

    assign rd_last = rd_load & (rd_col == 3'd7);

    // Write and read never touch the same flag in one cycle: a bank is written only while not full
    always_comb begin
        full_nxt = full;
        if (rd_last) full_nxt[rd_bank] = 1'b0;
        if (wr_fire && wr_row == 3'd7) full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_bank <= 1'b0;
            wr_row  <= 3'd0;
            rd_bank <= 1'b0;
            rd_col  <= 3'd0;
            full    <= 2'b00;
            valid   <= 1'b0;
        end else if (en) begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_row <= wr_row + 3'd1;
                if (wr_row == 3'd7) wr_bank <= ~wr_bank;
            end
            if (rd_start) begin
                rd_col <= 3'd0;
            end else if (rd_load) begin
                rd_col <= rd_col + 3'd1;
            end
            if (rd_last) rd_bank <= ~rd_bank;
            if (rd_load) begin
                valid <= 1'b1;
            end else if (valid && out_ready) begin
                valid <= 1'b0;
            end
        end
    end

    // Bank storage is never cleared; the full flags alone decide what is readable
    always_ff @(posedge clk) begin
        if (reset && wr_fire) begin
            for (int c = 0; c < 8; c++) begin
                bank[wr_bank][wr_row][c] <= din[c];
            end
        end
    end

    // Stage p1: column output register
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 8; k++) col_p1[k] <= '0;
        end else if (rd_load) begin
            for (int k = 0; k < 8; k++) col_p1[k] <= bank[rd_bank][k][rd_col];
        end
    end

    assign O0 = col_p1[0];
    assign O1 = col_p1[1];
    assign O2 = col_p1[2];
    assign O3 = col_p1[3];
    assign O4 = col_p1[4];
    assign O5 = col_p1[5];
    assign O6 = col_p1[6];
    assign O7 = col_p1[7];

endmodule
